// File: rtl/matmul_pkg.sv
// Shared types, constants and operand-indexing helpers for the 2x2 * 2x4
// matrix-multiply sequencer and its multiply-accumulate datapath.
package matmul_pkg;

    localparam int N_ENTRIES = 8;
    localparam int ELEM_W    = 4;
    localparam int OUT_W     = 8;
    localparam int ACC_W     = 2 * ELEM_W + 1;

    localparam logic [OUT_W-1:0] SAT_MAX = 8'hFF;
    localparam logic [2:0]       LAST_E  = 3'(N_ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC0,
        MAC1,
        WRITE,
        DONE
    } state_t;

    // A[i][k] lives at nibble 2i+k of the packed A operand
    function automatic logic [ELEM_W-1:0] a_elem(
        input logic [4*ELEM_W-1:0] a,
        input logic                i,
        input logic                k
    );
        logic [3:0] base;
        base = {i, k, 2'b00};
        return a[base +: ELEM_W];
    endfunction

    // B[k][j] lives at nibble 4k+j of the packed B operand
    function automatic logic [ELEM_W-1:0] b_elem(
        input logic [8*ELEM_W-1:0] b,
        input logic                k,
        input logic [1:0]          j
    );
        logic [4:0] base;
        base = {k, j, 2'b00};
        return b[base +: ELEM_W];
    endfunction

endpackage

// File: rtl/matmul_sequencer_mac_unit.sv
// Multiply-accumulate datapath: 4x4 unsigned multiply into a 9-bit
// accumulator, with the saturated 8-bit view of the value being written.
module mac_unit
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              accumulate,
    input  logic [ELEM_W-1:0] op_a,
    input  logic [ELEM_W-1:0] op_b,
    output logic [OUT_W-1:0]  sat_d
);

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [2*ELEM_W-1:0] prod;

    // Next accumulator value and its saturated form, so the caller can
    // register the result on the same edge the accumulator updates
    always_comb begin
        prod  = {{ELEM_W{1'b0}}, op_a} * {{ELEM_W{1'b0}}, op_b};
        acc_d = acc_q;
        if (load) begin
            acc_d = {1'b0, prod};
        end else if (accumulate) begin
            acc_d = acc_q + {1'b0, prod};
        end
        sat_d = (acc_d > ACC_W'(255)) ? SAT_MAX : acc_d[OUT_W-1:0];
    end

    // Accumulator register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for the 2x2 * 2x4 matrix product: latches operands on start,
// clears the register file, then produces each of the eight results with
// two MAC steps and writes them one at a time through the write port.
module matmul_sequencer #(
    parameter int ELEM_W = 4,
    parameter int OUT_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [4*ELEM_W-1:0] a_in,
    input  logic [8*ELEM_W-1:0] b_in,
    output logic                rf_clear,
    output logic                update_reg,
    output logic [2:0]          reg_specifier,
    output logic [OUT_W-1:0]    product_out,
    output logic                busy,
    output logic                done
);

    import matmul_pkg::*;

    state_t              state_q, state_d;
    logic [2:0]          e_q, e_d;
    logic [4*ELEM_W-1:0] a_q, a_d;
    logic [8*ELEM_W-1:0] b_q, b_d;
    logic [2:0]          spec_q, spec_d;
    logic [OUT_W-1:0]    prod_q, prod_d;

    logic                mac_load;
    logic                mac_accumulate;
    logic [ELEM_W-1:0]   mac_a;
    logic [ELEM_W-1:0]   mac_b;
    logic [OUT_W-1:0]    mac_sat_d;

    mac_unit u_mac (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (mac_load),
        .accumulate (mac_accumulate),
        .op_a       (mac_a),
        .op_b       (mac_b),
        .sat_d      (mac_sat_d)
    );

    // Next-state, datapath control and strobe decode; abort overrides the
    // transition and masks the strobes in the cycle it is seen
    always_comb begin
        state_d        = state_q;
        e_d            = e_q;
        a_d            = a_q;
        b_d            = b_q;
        spec_d         = spec_q;
        prod_d         = prod_q;
        mac_load       = 1'b0;
        mac_accumulate = 1'b0;
        mac_a          = a_elem(a_q, e_q[2], 1'b0);
        mac_b          = b_elem(b_q, 1'b0, e_q[1:0]);
        rf_clear       = 1'b0;
        update_reg     = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = CLEAR;
                    a_d     = a_in;
                    b_d     = b_in;
                end
            end
            CLEAR: begin
                rf_clear = 1'b1;
                busy     = 1'b1;
                e_d      = '0;
                state_d  = MAC0;
            end
            MAC0: begin
                busy     = 1'b1;
                mac_load = 1'b1;
                state_d  = MAC1;
            end
            MAC1: begin
                busy           = 1'b1;
                mac_accumulate = 1'b1;
                mac_a          = a_elem(a_q, e_q[2], 1'b1);
                mac_b          = b_elem(b_q, 1'b1, e_q[1:0]);
                spec_d         = e_q;
                prod_d         = mac_sat_d;
                state_d        = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                update_reg = 1'b1;
                e_d        = e_q + 3'd1;
                state_d    = (e_q == LAST_E) ? DONE : MAC0;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            rf_clear   = 1'b0;
            update_reg = 1'b0;
            done       = 1'b0;
        end
    end

    // State, element counter, operand latches and write-port registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            e_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            spec_q  <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            a_q     <= a_d;
            b_q     <= b_d;
            spec_q  <= spec_d;
            prod_q  <= prod_d;
        end
    end

    assign reg_specifier = spec_q;
    assign product_out   = prod_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Testbench for matmul_sequencer: directed table of operand sets plus
// random operands, checked cycle by cycle against a matrix-product model.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        rf_clear;
    logic        update_reg;
    logic [2:0]  reg_specifier;
    logic [7:0]  product_out;
    logic        busy;
    logic        done;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [15:0] a;
        logic [31:0] b;
        logic [63:0] expC;
        int          abortCycle;
        bit          holdStart;
        int          stopAt;
    } vec_t;

    vec_t vecTable[7];

    always #5 clk = ~clk;

    matmul_sequencer #(.ELEM_W(4), .OUT_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .a_in          (a_in),
        .b_in          (b_in),
        .rf_clear      (rf_clear),
        .update_reg    (update_reg),
        .reg_specifier (reg_specifier),
        .product_out   (product_out),
        .busy          (busy),
        .done          (done)
    );

    // Saturated C = A*B, element e = 4i+j packed at byte e
    function automatic logic [63:0] modelProduct(input logic [15:0] a, input logic [31:0] b);
        logic [63:0] c;
        int sum;
        c = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                sum = 0;
                for (int k = 0; k < 2; k++) begin
                    sum += int'(a[(2*i+k)*4 +: 4]) * int'(b[(4*k+j)*4 +: 4]);
                end
                c[(4*i+j)*8 +: 8] = (sum > 255) ? 8'hFF : 8'(sum);
            end
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Starts one run and checks every cycle from the accepting edge onwards
    task automatic applyStimulus(input vec_t v);
        int lastCyc;
        int e;
        bit aborted;
        logic expRf, expWr, expBusy, expDone;

        if (v.stopAt >= 0)           lastCyc = v.stopAt;
        else if (v.abortCycle >= 0)  lastCyc = v.abortCycle + 3;
        else if (v.holdStart)        lastCyc = 27;
        else                         lastCyc = 26;

        @(negedge clk);
        a_in  = v.a;
        b_in  = v.b;
        start = 1'b1;
        abort = 1'b0;
        @(posedge clk);

        for (int cyc = 0; cyc <= lastCyc; cyc++) begin
            @(negedge clk);
            if (!v.holdStart) start = 1'b0;
            if (cyc == 5) begin
                a_in = 16'($urandom);
                b_in = $urandom;
            end
            abort = (cyc == v.abortCycle);
            #1;

            aborted = (v.abortCycle >= 0) && (cyc > v.abortCycle);
            expRf = 1'b0; expWr = 1'b0; expBusy = 1'b0; expDone = 1'b0;
            if (aborted) begin
                expBusy = 1'b0;
            end else if (cyc <= 24) begin
                expBusy = 1'b1;
                expRf   = (cyc == 0);
                expWr   = (cyc >= 3) && (cyc % 3 == 0);
            end else if (cyc == 25) begin
                expDone = 1'b1;
            end else if (cyc == 27) begin
                expRf   = v.holdStart;
                expBusy = v.holdStart;
            end
            if (cyc == v.abortCycle) begin
                expRf = 1'b0; expWr = 1'b0; expDone = 1'b0;
            end

            checkOutput($sformatf("ctl{rf,upd,busy,done} cyc=%0d", cyc),
                        64'({rf_clear, update_reg, busy, done}),
                        64'({expRf, expWr, expBusy, expDone}));
            if (expWr) begin
                e = cyc / 3 - 1;
                checkOutput($sformatf("reg_specifier cyc=%0d", cyc), 64'(reg_specifier), 64'(e));
                checkOutput($sformatf("product_out e=%0d", e), 64'(product_out), 64'(v.expC[e*8 +: 8]));
            end
        end

        if (v.stopAt < 0) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        vec_t v;

        vecTable[0] = '{16'h1001, 32'h87654321, 64'h0807060504030201, -1, 1'b0, -1};
        vecTable[1] = '{16'hFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, -1, 1'b0, -1};
        vecTable[2] = '{16'h001F, 32'h000F000F, 64'h00000000000000F0, -1, 1'b0, -1};
        vecTable[3] = '{16'h004E, 32'h000F000E, 64'h00000000000000FF, -1, 1'b0, -1};
        vecTable[4] = '{16'h5432, 32'hF013F201, 64'h870805134B04030B, -1, 1'b0, -1};
        vecTable[5] = '{16'h1001, 32'h87654321, 64'h0807060504030201, -1, 1'b1, -1};
        vecTable[6] = '{16'h1001, 32'h87654321, 64'h0807060504030201, 10, 1'b0, -1};

        #2;
        checkOutput("reset outputs",
                    64'({rf_clear, update_reg, reg_specifier, product_out, busy, done}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < 7; n++) begin
            applyStimulus(vecTable[n]);
        end

        // Reset asserted in the middle of a run, then a clean run afterwards
        v = vecTable[0];
        v.stopAt = 14;
        applyStimulus(v);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("mid-run reset outputs",
                    64'({rf_clear, update_reg, reg_specifier, product_out, busy, done}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        v.a = 16'($urandom);
        v.b = $urandom;
        v.expC = modelProduct(v.a, v.b);
        v.stopAt = -1;
        applyStimulus(v);

        for (int n = 0; n < 8; n++) begin
            v.a = 16'($urandom);
            v.b = $urandom;
            v.expC = modelProduct(v.a, v.b);
            v.abortCycle = (n % 4 == 3) ? int'($urandom_range(0, 25)) : -1;
            v.holdStart = 1'b0;
            v.stopAt = -1;
            applyStimulus(v);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
